// File: rtl/strat_sched.sv
// strat_sched: per-symbol one-entry update slots, round-robin issue to a
// shared decide unit, symbol-tagged result reporting and per-symbol cooldown.
module strat_sched #(
  parameter int W        = 32,
  parameter int N        = 4,
  parameter int LAT      = 1,
  parameter int COOLDOWN = 8,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_bid,
  input  logic [N*W-1:0]   req_ask,
  input  logic [N*W-1:0]   req_fair,
  output logic [W-1:0]     dec_bid_px0,
  output logic [W-1:0]     dec_ask_px0,
  output logic [W-1:0]     dec_fair_px,
  output logic             dec_in_valid,
  input  logic             dec_buy,
  input  logic             dec_sell,
  input  logic             dec_out_valid,
  output logic             sig_valid,
  output logic             sig_buy,
  output logic             sig_sell,
  output logic [IW-1:0]    sig_id,
  output logic             busy,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;

  logic [W-1:0]    r_bid  [N];
  logic [W-1:0]    r_ask  [N];
  logic [W-1:0]    r_fair [N];
  logic [N-1:0]    r_pend;
  logic [7:0]      r_cool [N];
  logic [IW-1:0]   r_rr_ptr;

  logic [W-1:0]    r_dec_bid, r_dec_ask, r_dec_fair;
  logic            r_dec_in_valid;
  logic [IW-1:0]   r_issue_id;

  logic [LAT-1:0]  r_tag_v;
  logic [IW-1:0]   r_tag_id [LAT];

  logic            r_sig_valid, r_sig_buy, r_sig_sell;
  logic [IW-1:0]   r_sig_id;
  logic [15:0]     r_drop_cnt;

  logic [N-1:0]    w_elig, w_gnt_oh, w_drop;
  logic            w_gnt_v;
  logic [IW-1:0]   w_gnt_id, w_idx;
  logic [4:0]      w_drop_num;
  logic [16:0]     w_drop_sum;
  logic            w_inflight, w_tag_out_v, w_res, w_trade;
  logic [IW-1:0]   w_tag_out_id;

  assign w_tag_out_v  = r_tag_v[LAT-1];
  assign w_tag_out_id = r_tag_id[LAT-1];
  // A result only counts when a live tag backs it; stale returns after reset are dropped.
  assign w_res        = dec_out_valid & w_tag_out_v;
  assign w_trade      = w_res & (dec_buy | dec_sell);
  assign w_inflight   = r_dec_in_valid | (|r_tag_v);

  // Eligibility and round-robin search upward from the pointer (N is a power of two, so IW-bit add wraps).
  always_comb begin
    w_gnt_v  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_elig[i] = r_pend[i] && (r_cool[i] == 8'd0) && (r_state == S_RUN);
    end
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = r_rr_ptr + IW'(k);
      if (!w_gnt_v && w_elig[w_idx]) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    w_gnt_oh = '0;
    if (w_gnt_v) w_gnt_oh[w_gnt_id] = 1'b1;
  end

  // Overwrite detection; an update coinciding with its own grant is not a drop.
  always_comb begin
    w_drop_num = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_drop[i]  = req_valid[i] & r_pend[i] & ~w_gnt_oh[i];
      w_drop_num = w_drop_num + {4'd0, w_drop[i]};
    end
    w_drop_sum = {1'b0, r_drop_cnt} + {12'd0, w_drop_num};
  end

  // Slot storage, pending bits and cooldown counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_bid[i]  <= '0;
        r_ask[i]  <= '0;
        r_fair[i] <= '0;
        r_cool[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          r_bid[i]  <= req_bid[i*W +: W];
          r_ask[i]  <= req_ask[i*W +: W];
          r_fair[i] <= req_fair[i*W +: W];
        end
        r_pend[i] <= req_valid[i] | (r_pend[i] & ~w_gnt_oh[i]);
        if (w_trade && (w_tag_out_id == IW'(i)))
          r_cool[i] <= 8'(COOLDOWN);
        else if (r_cool[i] != 8'd0)
          r_cool[i] <= r_cool[i] - 8'd1;
      end
    end
  end

  // Issue register towards the decide unit and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dec_in_valid <= 1'b0;
      r_dec_bid      <= '0;
      r_dec_ask      <= '0;
      r_dec_fair     <= '0;
      r_issue_id     <= '0;
      r_rr_ptr       <= '0;
    end else begin
      r_dec_in_valid <= w_gnt_v;
      if (w_gnt_v) begin
        r_dec_bid  <= r_bid[w_gnt_id];
        r_dec_ask  <= r_ask[w_gnt_id];
        r_dec_fair <= r_fair[w_gnt_id];
        r_issue_id <= w_gnt_id;
        r_rr_ptr   <= w_gnt_id + 1'b1;
      end
    end
  end

  // Tag pipeline: stage LAT-1 lines up with dec_out_valid for the matching issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      for (int unsigned s = 0; s < LAT; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_v[0]  <= r_dec_in_valid;
      r_tag_id[0] <= r_issue_id;
      for (int unsigned s = 1; s < LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Registered, symbol-tagged result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig_valid <= 1'b0;
      r_sig_buy   <= 1'b0;
      r_sig_sell  <= 1'b0;
      r_sig_id    <= '0;
    end else begin
      r_sig_valid <= w_res;
      r_sig_buy   <= w_res & dec_buy;
      r_sig_sell  <= w_res & dec_sell;
      if (w_res) r_sig_id <= w_tag_out_id;
    end
  end

  // Saturating overwrite counter.
  always_ff @(posedge clk) begin
    if (!rst_n)             r_drop_cnt <= '0;
    else if (w_drop_sum[16]) r_drop_cnt <= 16'hFFFF;
    else                    r_drop_cnt <= w_drop_sum[15:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = w_inflight ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (enable)           w_state_nxt = S_RUN;
        else if (!w_inflight) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dec_bid_px0  = r_dec_bid;
  assign dec_ask_px0  = r_dec_ask;
  assign dec_fair_px  = r_dec_fair;
  assign dec_in_valid = r_dec_in_valid;
  assign sig_valid    = r_sig_valid;
  assign sig_buy      = r_sig_buy;
  assign sig_sell     = r_sig_sell;
  assign sig_id       = r_sig_id;
  assign busy         = (r_state != S_IDLE);
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_strat_sched.sv
// Directed bench for strat_sched with a LAT=1 decide-unit model:
// buy when fair > ask, sell when fair < bid.
module tb_strat_sched;

  localparam int W = 32;
  localparam int N = 4;
  localparam int LAT = 1;
  localparam int CD = 8;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_bid, req_ask, req_fair;
  logic [W-1:0]   dec_bid_px0, dec_ask_px0, dec_fair_px;
  logic           dec_in_valid;
  logic           dec_buy, dec_sell, dec_out_valid;
  logic           sig_valid, sig_buy, sig_sell;
  logic [1:0]     sig_id;
  logic           busy;
  logic [15:0]    drop_cnt;
  logic           junk;

  int n_vec = 0;
  int n_err = 0;

  strat_sched #(.W(W), .N(N), .LAT(LAT), .COOLDOWN(CD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid),
    .req_bid(req_bid), .req_ask(req_ask), .req_fair(req_fair),
    .dec_bid_px0(dec_bid_px0), .dec_ask_px0(dec_ask_px0), .dec_fair_px(dec_fair_px),
    .dec_in_valid(dec_in_valid), .dec_buy(dec_buy), .dec_sell(dec_sell),
    .dec_out_valid(dec_out_valid), .sig_valid(sig_valid), .sig_buy(sig_buy),
    .sig_sell(sig_sell), .sig_id(sig_id), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decide-unit model; junk drives buy/sell without a valid strobe.
  always @(posedge clk) begin
    dec_out_valid <= dec_in_valid;
    dec_buy       <= junk | (dec_in_valid & (dec_fair_px > dec_ask_px0));
    dec_sell      <= junk | (dec_in_valid & (dec_fair_px < dec_bid_px0));
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic upd(input int i, input logic [31:0] b, input logic [31:0] a, input logic [31:0] f);
    req_valid[i]        = 1'b1;
    req_bid[i*W +: W]   = b;
    req_ask[i*W +: W]   = a;
    req_fair[i*W +: W]  = f;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; req_valid = '0; junk = 1'b0;
    req_bid = '0; req_ask = '0; req_fair = '0;
    dec_out_valid = 1'b0; dec_buy = 1'b0; dec_sell = 1'b0;
    tick(); tick();
    chk("rst_dec_in_valid", dec_in_valid, 0);
    chk("rst_sig_valid", sig_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_sig_id", sig_id, 0);
    chk("rst_dec_bid", dec_bid_px0, 0);

    rst_n = 1'b1; enable = 1'b1;
    tick();
    chk("run_busy", busy, 1);

    // Burst of all four symbols, twice.
    for (int i = 0; i < N; i++) upd(i, 200 + i, 300 + i, 250 + i);
    tick();
    chk("b1_wait", dec_in_valid, 0);
    for (int k = 0; k < N; k++) begin
      tick();
      chk("b1_valid", dec_in_valid, 1);
      chk("b1_order", dec_bid_px0, 200 + k);
    end
    for (int i = 0; i < N; i++) upd(i, 400 + i, 500 + i, 450 + i);
    tick();
    chk("b2_wait", dec_in_valid, 0);
    for (int k = 0; k < N; k++) begin
      tick();
      chk("b2_valid", dec_in_valid, 1);
      chk("b2_order", dec_bid_px0, 400 + k);
    end
    tick();
    chk("b2_end", dec_in_valid, 0);
    chk("b2_sig_valid", sig_valid, 1);
    chk("b2_sig_id2", sig_id, 2);
    tick();
    chk("b2_sig_id3", sig_id, 3);

    // Single update, no trade.
    upd(2, 10000, 10010, 10005);
    tick();
    chk("s2_e0", dec_in_valid, 0);
    tick();
    chk("s2_e1_valid", dec_in_valid, 1);
    chk("s2_bid", dec_bid_px0, 10000);
    chk("s2_ask", dec_ask_px0, 10010);
    chk("s2_fair", dec_fair_px, 10005);
    tick();
    chk("s2_e2_single", dec_in_valid, 0);
    chk("s2_e2_sig", sig_valid, 0);
    tick();
    chk("s2_e3_sig", sig_valid, 1);
    chk("s2_e3_id", sig_id, 2);
    chk("s2_e3_buy", sig_buy, 0);
    chk("s2_e3_sell", sig_sell, 0);
    tick();
    chk("s2_e4_sig", sig_valid, 0);

    // Update coinciding with grant.
    upd(0, 500, 510, 505);
    tick();
    upd(0, 600, 610, 605);
    tick();
    chk("cg_old_valid", dec_in_valid, 1);
    chk("cg_old_bid", dec_bid_px0, 500);
    tick();
    chk("cg_new_valid", dec_in_valid, 1);
    chk("cg_new_bid", dec_bid_px0, 600);
    chk("cg_drop", drop_cnt, 0);
    tick(); tick(); tick();

    // Buy/sell without valid is ignored.
    junk = 1'b1;
    tick(); tick();
    chk("junk_sig_valid", sig_valid, 0);
    chk("junk_sig_buy", sig_buy, 0);
    chk("junk_sig_sell", sig_sell, 0);
    junk = 1'b0;
    tick();

    // Buy result then cooldown with continuous overwrites.
    upd(1, 10000, 10010, 10020);
    tick();
    tick();
    chk("cd_issue", dec_in_valid, 1);
    tick();
    tick();
    chk("cd_sig_valid", sig_valid, 1);
    chk("cd_sig_id", sig_id, 1);
    chk("cd_sig_buy", sig_buy, 1);
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) upd(1, 2000 + k, 2010 + k, 2005 + k);
      tick();
      chk("cd_block", dec_in_valid, (k == 9) ? 1 : 0);
    end
    chk("cd_latest_bid", dec_bid_px0, 2008);
    chk("cd_drop", drop_cnt, 7);
    tick(); tick(); tick();

    // Enable dropped during flight: DRAIN then IDLE.
    upd(2, 10000, 10010, 9990);
    tick();
    tick();
    chk("dr_issue", dec_in_valid, 1);
    enable = 1'b0;
    tick();
    chk("dr_busy_e2", busy, 1);
    tick();
    chk("dr_sig_valid", sig_valid, 1);
    chk("dr_sig_sell", sig_sell, 1);
    chk("dr_sig_id", sig_id, 2);
    chk("dr_busy_e3", busy, 1);
    tick();
    chk("dr_idle_busy", busy, 0);
    upd(3, 700, 710, 705);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_no_issue", dec_in_valid, 0);
    end
    enable = 1'b1;
    tick();
    chk("re_run_busy", busy, 1);
    chk("re_run_wait", dec_in_valid, 0);
    tick();
    chk("re_run_issue", dec_in_valid, 1);
    chk("re_run_bid", dec_bid_px0, 700);
    chk("re_run_drop", drop_cnt, 7);
    tick(); tick(); tick();

    // Reset with a tag in flight.
    upd(0, 800, 810, 805);
    tick();
    tick();
    chk("rf_issue", dec_in_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("rf_dec_in_valid", dec_in_valid, 0);
    chk("rf_sig_valid", sig_valid, 0);
    chk("rf_busy", busy, 0);
    chk("rf_drop", drop_cnt, 0);
    chk("rf_dec_bid", dec_bid_px0, 0);
    chk("rf_sig_id", sig_id, 0);
    chk("rf_sig_buy", sig_buy, 0);
    rst_n = 1'b1;
    tick();
    chk("rf_no_sig_e3", sig_valid, 0);
    chk("rf_busy_e3", busy, 1);
    tick();
    chk("rf_no_sig_e4", sig_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
